// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-through cache controller.
package cache_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      MEM_REQ  = 3'd2,
      MEM_WAIT = 3'd3,
      RESP     = 3'd4
   } cache_state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } cache_req_t;

   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

endpackage

// File: rtl/dm_line_store.sv
// One-word-per-line valid/tag/data store: combinational read, one write port,
// and a tag-qualified clear-valid port that overrides the write.
module dm_line_store #(
   parameter int NUM_LINES = 16,
   parameter int IDX_W     = 4,
   parameter int TAG_W     = 12,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_en,
   input  logic [IDX_W-1:0]  clr_idx,
   input  logic [TAG_W-1:0]  clr_tag
);

   logic [NUM_LINES-1:0] valid_r;
   logic [TAG_W-1:0]     tag_r  [NUM_LINES];
   logic [DATA_W-1:0]    data_r [NUM_LINES];
   logic [NUM_LINES-1:0] clr_mask_s;
   logic [NUM_LINES-1:0] wr_mask_s;

   // Clear compares against the tag the line will hold after this edge
   always_comb begin
      clr_mask_s = '0;
      wr_mask_s  = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (wr_en && (wr_idx == IDX_W'(i))) begin
            wr_mask_s[i]  = 1'b1;
            clr_mask_s[i] = clr_en && (clr_idx == IDX_W'(i)) && (clr_tag == wr_tag);
         end else begin
            wr_mask_s[i]  = 1'b0;
            clr_mask_s[i] = clr_en && (clr_idx == IDX_W'(i)) && (clr_tag == tag_r[i]);
         end
      end
   end

   // Valid bits: reset clears all, clear beats write
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
      end else begin
         valid_r <= (valid_r | wr_mask_s) & ~clr_mask_s;
      end
   end

   // Tag and data arrays need no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_r[wr_idx]  <= wr_tag;
         data_r[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_r[rd_idx];
   assign rd_tag   = tag_r[rd_idx];
   assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// snoop invalidate port.
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int NUM_LINES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_ready,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              inv_valid,
   input  logic [ADDR_W-1:0] inv_addr
);

   localparam int IDX_W = idx_w(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   cache_state_e      state_r, next_s;
   cache_req_t        req_r;
   logic              mem_write_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] cpu_rdata_r;
   logic              line_valid_s;
   logic [TAG_W-1:0]  line_tag_s;
   logic [DATA_W-1:0] line_data_s;
   logic              hit_s;
   logic              wr_en_s;
   logic [DATA_W-1:0] wr_data_s;
   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s;

   assign idx_s = req_r.addr[IDX_W-1:0];
   assign tag_s = req_r.addr[ADDR_W-1:IDX_W];
   assign hit_s = line_valid_s && (line_tag_s == tag_s);

   // Array write: store-hit update in LOOKUP, fill on a load response
   always_comb begin
      wr_en_s   = 1'b0;
      wr_data_s = mem_rdata;
      if (state_r == LOOKUP) begin
         wr_en_s   = req_r.write && hit_s;
         wr_data_s = req_r.wdata;
      end else if (state_r == MEM_WAIT) begin
         wr_en_s   = !req_r.write && mem_rsp_valid;
         wr_data_s = mem_rdata;
      end else begin
         wr_en_s   = 1'b0;
         wr_data_s = mem_rdata;
      end
   end

   dm_line_store #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W),
      .DATA_W    (DATA_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx_s),
      .rd_valid (line_valid_s),
      .rd_tag   (line_tag_s),
      .rd_data  (line_data_s),
      .wr_en    (wr_en_s),
      .wr_idx   (idx_s),
      .wr_tag   (tag_s),
      .wr_data  (wr_data_s),
      .clr_en   (inv_valid),
      .clr_idx  (inv_addr[IDX_W-1:0]),
      .clr_tag  (inv_addr[ADDR_W-1:IDX_W])
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE:     next_s = cpu_req_valid ? LOOKUP : IDLE;
         LOOKUP:   next_s = (!req_r.write && hit_s) ? RESP : MEM_REQ;
         MEM_REQ:  next_s = mem_ready ? MEM_WAIT : MEM_REQ;
         MEM_WAIT: next_s = mem_rsp_valid ? RESP : MEM_WAIT;
         RESP:     next_s = IDLE;
         default:  next_s = IDLE;
      endcase
   end

   // Handshake outputs decoded straight from the state register
   always_comb begin
      cpu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      cpu_rsp_valid = 1'b0;
      case (state_r)
         IDLE:    cpu_req_ready = 1'b1;
         MEM_REQ: mem_req_valid = 1'b1;
         RESP:    cpu_rsp_valid = 1'b1;
         default: cpu_req_ready = 1'b0;
      endcase
   end

   // Request capture, memory request fields and CPU read data
   always_ff @(posedge clk) begin
      if (rst) begin
         req_r       <= '0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         cpu_rdata_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cpu_req_valid) begin
                  req_r.write <= cpu_write;
                  req_r.addr  <= cpu_addr;
                  req_r.wdata <= cpu_wdata;
               end
            end
            LOOKUP: begin
               if (!req_r.write && hit_s) begin
                  cpu_rdata_r <= line_data_s;
               end else begin
                  mem_write_r <= req_r.write;
                  mem_addr_r  <= req_r.addr;
                  mem_wdata_r <= req_r.write ? req_r.wdata : '0;
               end
            end
            MEM_WAIT: begin
               if (mem_rsp_valid) begin
                  cpu_rdata_r <= req_r.write ? '0 : mem_rdata;
               end
            end
            default: begin
               cpu_rdata_r <= cpu_rdata_r;
            end
         endcase
      end
   end

   assign mem_write = mem_write_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign cpu_rdata = cpu_rdata_r;

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Cache-side initiator of the cache/memory interface: a direct-mapped, write-through, no-write-allocate cache controller.
- Accepts word-granular CPU loads and stores.
- Issues memory read requests on load misses and forwards every store to the memory-side responder.
- Supports a snoop invalidate port for the coherence lab.

Parameters:
ADDR_W, 16, word address width
DATA_W, 32, data word width
NUM_LINES, 16, number of one-word lines; power of 2, >= 2 (IDX_W = log2(NUM_LINES))

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller can accept a request
cpu_write  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  store data
cpu_rsp_valid  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load data, valid with cpu_rsp_valid
mem_req_valid  out  1  request to memory
mem_ready  in  1  memory accepts request this cycle
mem_write  out  1  request is a write
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_rsp_valid  in  1  read data returned or write acknowledged
mem_rdata  in  DATA_W  read data
inv_valid  in  1  snoop invalidate
inv_addr  in  ADDR_W  address to invalidate

Behaviour:
- Reset (rst=1 at posedge):
  - all line valid bits cleared; state IDLE.
  - cpu_req_ready=1, cpu_rsp_valid=0, mem_req_valid=0, mem_write=0.
  - cpu_rdata, mem_addr, mem_wdata = 0.
- Address split: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
- IDLE: cpu_req_ready=1 only here. cpu_req_valid&cpu_req_ready captures write/addr/wdata, then -> LOOKUP.
- LOOKUP: hit = valid[index] && tag match.
  - Load hit: cpu_rdata <= line data, -> RESP.
  - Load miss: -> MEM_REQ with mem_write=0.
  - Store: on hit, line data updated to wdata; on miss, no allocate. Either way -> MEM_REQ with mem_write=1, mem_wdata=wdata.
- MEM_REQ: mem_req_valid=1; mem_addr/mem_write/mem_wdata held stable until mem_ready=1 in the same cycle, then -> MEM_WAIT. mem_req_valid deasserts the next cycle.
- MEM_WAIT: wait indefinitely for mem_rsp_valid.
  - Load: line[index] <= {tag, mem_rdata}, valid set; cpu_rdata <= mem_rdata.
  - Store: acknowledge only; cpu_rdata <= 0.
  - Then -> RESP.
- RESP: cpu_rsp_valid=1 for exactly one cycle, -> IDLE.
- Latency from the accept edge:
  - load hit: cpu_rsp_valid at cycle +2.
  - miss/store: +2 to mem_req_valid, then response the cycle after the mem_rsp_valid cycle.
- Stalled memory: mem_ready=0 holds the MEM_REQ state forever.
- mem_rsp_valid outside MEM_WAIT is ignored (no state or array change).
- Invalidate: inv_valid clears valid[index(inv_addr)] when its tag matches; accepted in every state.
- Invalidate vs fill, same cycle and same line: invalidate wins. Line is left invalid, but the CPU still receives mem_rdata.
- Invalidate vs LOOKUP, same cycle and same line: the lookup uses the pre-invalidate valid bit.
- Reset mid-operation: transaction abandoned without a CPU response. A late mem_rsp_valid arrives in IDLE and is ignored.

Decomposition:
- Package cache_pkg:
  - state enum cache_state_e;
  - function computing IDX_W;
  - struct cache_req_t {write, addr, wdata};
  - localparam defaults for ADDR_W/DATA_W.
- Sub-module dm_line_store: valid/tag/data arrays with one read port (combinational on index), one write port (fill/store update) and a clear-valid port (invalidate, priority over write).

Test Plan:
- Reset, then load 0x0013 with memory returning 0xDEADBEEF after 3 cycles -> one mem read at addr 0x0013; cpu_rsp_valid pulse with cpu_rdata=0xDEADBEEF.
- Load 0x0013 again -> no mem request; cpu_rdata=0xDEADBEEF 2 cycles after accept.
- Store 0x0013 = 0x12345678 -> mem write with mem_wdata=0x12345678, response after the ack. A following load of 0x0013 hits and returns 0x12345678. A store to 0x0023 (same index, miss) leaves the line unchanged.
- Load 0x0023 while mem_ready is held 0 for 5 cycles -> mem_req_valid and mem_addr=0x0023 stable for 5 cycles; cpu_req_ready=0 throughout.
- inv_valid with inv_addr=0x0013 in the same cycle as the fill for load 0x0013 -> CPU gets the fill data; the next load of 0x0013 misses and goes to memory.
- Assert rst during MEM_WAIT, then drive mem_rsp_valid -> no cpu_rsp_valid; all lines invalid; cpu_req_ready=1.
